// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_edge input stage.
// Holds the FSM encoding, default qualification length and event counter width.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned EVT_CNT_W         = 8;

    // Idle state that matches a given resting level
    function automatic state_t reset_state(input logic lvl);
        return lvl ? ST_HIGH : ST_LOW;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs.
// Both stages take RESET_VAL while rst is low.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/debounce_edge.sv
// Debounce and edge-detect stage: sync, qualify for STABLE_CYCLES, emit pulses.
// Optional macro DEBOUNCE_EVT_CNT_EN adds an 8-bit accepted-transition counter.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
`ifdef DEBOUNCE_EVT_CNT_EN
    output logic busy,
    output logic [EVT_CNT_W-1:0] evt_cnt
`else
    output logic busy
`endif
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    // With a one-cycle window the first differing sample is accepted at once
    localparam logic DIRECT = (STABLE_CYCLES == 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    logic w_sync;
    logic w_acc_rise;
    logic w_acc_fall;
    logic w_last;

    sync_2ff #(
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d_in),
        .q   (w_sync)
    );

    assign w_last = (r_cnt == CNT_LAST);

    assign w_acc_rise = w_sync &
        (((r_state == ST_LOW) & DIRECT) |
         ((r_state == ST_RISE_WAIT) & w_last));

    assign w_acc_fall = ~w_sync &
        (((r_state == ST_HIGH) & DIRECT) |
         ((r_state == ST_FALL_WAIT) & w_last));

    // Qualification FSM with registered level, pulses and busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= reset_state(RESET_LEVEL);
            r_cnt   <= '0;
            r_level <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rise <= w_acc_rise;
            r_fall <= w_acc_fall;
            unique case (r_state)
                ST_LOW: begin
                    r_level <= 1'b0;
                    if (w_acc_rise) begin
                        r_state <= ST_HIGH;
                        r_level <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_sync) begin
                        r_state <= ST_RISE_WAIT;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_RISE_WAIT: begin
                    if (!w_sync) begin
                        r_state <= ST_LOW;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_acc_rise) begin
                        r_state <= ST_HIGH;
                        r_level <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    r_level <= 1'b1;
                    if (w_acc_fall) begin
                        r_state <= ST_LOW;
                        r_level <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (!w_sync) begin
                        r_state <= ST_FALL_WAIT;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_FALL_WAIT: begin
                    if (w_sync) begin
                        r_state <= ST_HIGH;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_acc_fall) begin
                        r_state <= ST_LOW;
                        r_level <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EVT_CNT_EN
    logic [EVT_CNT_W-1:0] r_evt_cnt;

    // Count accepted transitions on the same edge the pulse rises; wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_cnt <= '0;
        end else if (w_acc_rise | w_acc_fall) begin
            r_evt_cnt <= r_evt_cnt + EVT_CNT_W'(1);
        end
    end

    assign evt_cnt = r_evt_cnt;
`endif

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;

endmodule
